// File: rtl/bus_dispatcher_if.sv
// FIFO-side and bus-side signal bundle for bus_dispatcher.
// master = dispatcher side, slave = FIFO/bus environment side.
interface bus_dispatcher_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 8;
  localparam int unsigned ADDR_W = 16;

  logic [DATA_W-1:0] out_fifo;
  logic              empty;
  logic              read_fifo_en;
  logic              bus_valid;
  logic              bus_ready;
  logic [DEST_W-1:0] bus_dest;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;

  modport master (
    input  out_fifo, empty, bus_ready,
    output read_fifo_en, bus_valid, bus_dest, bus_addr, bus_data, bus_last
  );

  modport slave (
    output out_fifo, empty, bus_ready,
    input  read_fifo_en, bus_valid, bus_dest, bus_addr, bus_data, bus_last
  );
endinterface

// File: rtl/bus_dispatcher.sv
// Pops header+payload packets from a show-ahead FIFO and emits them as
// addressed bus beats with a valid/ready handshake.
module bus_dispatcher #(
  parameter int unsigned LEN_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  bus_dispatcher_if.master   bus,
  output logic               hdr_err,
  output logic [15:0]        pkt_count,
  output logic               busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEST_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   index_q, index_d;
  logic               valid_d, last_d;
  logic [DEST_W-1:0]  dest_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  data_d;
  logic               hdr_err_d;
  logic [CNT_W-1:0]   pkt_count_d;
  logic               pop;
  logic               slot_free;
  logic [LEN_W-1:0]   hdr_len;

  assign hdr_len   = bus.out_fifo[LEN_W-1:0];
  assign slot_free = !bus.bus_valid || bus.bus_ready;

  // Pop is masked by reset so the FIFO is never drained while held in reset.
  assign bus.read_fifo_en = pop && reset;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state;
    base_d      = base_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    valid_d     = bus.bus_valid;
    last_d      = bus.bus_last;
    dest_d      = bus.bus_dest;
    addr_d      = bus.bus_addr;
    data_d      = bus.bus_data;
    hdr_err_d   = 1'b0;
    pkt_count_d = pkt_count;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.empty) begin
          pop = 1'b1;
          if (hdr_len == '0) begin
            hdr_err_d = 1'b1;
          end else begin
            dest_d      = bus.out_fifo[31:24];
            base_d      = bus.out_fifo[23:8];
            remaining_d = hdr_len;
            index_d     = '0;
            state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.empty && slot_free) begin
          pop         = 1'b1;
          data_d      = bus.out_fifo;
          addr_d      = base_q + ADDR_W'(index_q);
          valid_d     = 1'b1;
          last_d      = (remaining_q == LEN_W'(1));
          remaining_d = remaining_q - LEN_W'(1);
          index_d     = index_q + LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end else if (bus.bus_valid && bus.bus_ready) begin
          // Accepted with nothing to refill: bubble rather than repeat.
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.bus_ready) begin
          valid_d     = 1'b0;
          last_d      = 1'b0;
          pkt_count_d = pkt_count + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base_q       <= '0;
      remaining_q  <= '0;
      index_q      <= '0;
      bus.bus_valid <= 1'b0;
      bus.bus_last  <= 1'b0;
      bus.bus_dest  <= '0;
      bus.bus_addr  <= '0;
      bus.bus_data  <= '0;
      hdr_err      <= 1'b0;
      pkt_count    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      base_q       <= base_d;
      remaining_q  <= remaining_d;
      index_q      <= index_d;
      bus.bus_valid <= valid_d;
      bus.bus_last  <= last_d;
      bus.bus_dest  <= dest_d;
      bus.bus_addr  <= addr_d;
      bus.bus_data  <= data_d;
      hdr_err      <= hdr_err_d;
      pkt_count    <= pkt_count_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_dispatcher.sv
// Directed bench for bus_dispatcher: a queue-backed show-ahead FIFO feeds
// packets and accepted bus beats are captured for comparison.
module tb_bus_dispatcher;
  localparam int unsigned LEN_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdr_err;
  logic [15:0] pkt_count;
  logic        busy;

  bus_dispatcher_if ifc();

  bus_dispatcher #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc),
    .hdr_err   (hdr_err),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  dest;
    logic [15:0] addr;
    logic [31:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] fq[$];
  logic        stall;
  logic        last_rd;
  int          checks;
  int          failures;
  int          cyc;
  int          pops;
  int          hdr_pulses;

  function automatic logic [56:0] pk(beat_t b);
    return {b.dest, b.addr, b.data, b.last};
  endfunction

  task automatic drive_fifo();
    ifc.empty    = stall || (fq.size() == 0);
    ifc.out_fifo = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  // One clock: sample handshakes before the edge, update FIFO model after.
  task automatic step();
    beat_t       b;
    logic        rd;
    logic        acc;
    logic [31:0] w;
    drive_fifo();
    #1;
    rd     = ifc.read_fifo_en;
    acc    = ifc.bus_valid && ifc.bus_ready && reset;
    b.dest = ifc.bus_dest;
    b.addr = ifc.bus_addr;
    b.data = ifc.bus_data;
    b.last = ifc.bus_last;
    b.cyc  = cyc;
    if (rd === 1'b1) begin
      checks++;
      if (ifc.empty !== 1'b0) begin
        failures++;
        $display("FAIL pop_when_empty read_fifo_en=%b empty=%b (empty must be 0)", rd, ifc.empty);
      end
    end
    @(posedge clk);
    cyc++;
    if (rd === 1'b1 && fq.size() != 0) begin
      w = fq.pop_front();
      pops++;
    end
    if (acc) beats.push_back(b);
    last_rd = rd;
    #1;
    if (hdr_err === 1'b1) hdr_pulses++;
  endtask

  task automatic wait_beats(input int n, input int max_cyc);
    int k = 0;
    while (beats.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    checks++;
    if (beats.size() < n) begin
      failures++;
      $display("FAIL wait_beats timeout got=%0d need=%0d", beats.size(), n);
    end
  endtask

  task automatic wait_pops(input int n, input int max_cyc);
    int k = 0;
    while (pops < n && k < max_cyc) begin
      step();
      k++;
    end
    checks++;
    if (pops < n) begin
      failures++;
      $display("FAIL wait_pops timeout got=%0d need=%0d", pops, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.bus_ready = 1'b0;
    stall = 1'b0;
    fq = '{32'h0A010003};
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if (ifc.read_fifo_en !== 1'b0 || pops !== 0) begin
      failures++;
      $display("FAIL reset_no_pop read_fifo_en=%b pops=%0d expected 0/0", ifc.read_fifo_en, pops);
    end
    checks++;
    if ({ifc.bus_valid, ifc.bus_last, ifc.bus_dest, ifc.bus_addr, ifc.bus_data} !== 58'h0) begin
      failures++;
      $display("FAIL reset_bus valid=%b last=%b dest=%h addr=%h data=%h expected all 0",
               ifc.bus_valid, ifc.bus_last, ifc.bus_dest, ifc.bus_addr, ifc.bus_data);
    end
    checks++;
    if ({hdr_err, busy, pkt_count} !== 18'h0) begin
      failures++;
      $display("FAIL reset_status hdr_err=%b busy=%b pkt_count=%h expected 0", hdr_err, busy, pkt_count);
    end
    fq.delete();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [56:0] exp_b [3];
    exp_b[0] = {8'h0A, 16'h0100, 32'h11, 1'b0};
    exp_b[1] = {8'h0A, 16'h0101, 32'h22, 1'b0};
    exp_b[2] = {8'h0A, 16'h0102, 32'h33, 1'b1};
    beats.delete();
    pops = 0;
    ifc.bus_ready = 1'b1;
    fq = '{32'h0A010003, 32'h11, 32'h22, 32'h33};
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_busy got=%b expected 0", busy);
    end
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_after_hdr got=%b expected 1", busy);
    end
    wait_beats(3, 20);
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      checks++;
      if (pk(beats[i]) !== exp_b[i]) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h expected=%h", i, pk(beats[i]), exp_b[i]);
      end
    end
    checks++;
    if (beats[1].cyc - beats[0].cyc !== 1 || beats[2].cyc - beats[1].cyc !== 1) begin
      failures++;
      $display("FAIL basic_back_to_back gaps=%0d,%0d expected 1,1",
               beats[1].cyc - beats[0].cyc, beats[2].cyc - beats[1].cyc);
    end
    checks++;
    if ({pkt_count, busy, ifc.bus_valid, ifc.bus_last} !== {16'd1, 3'b000}) begin
      failures++;
      $display("FAIL basic_done pkt_count=%0d busy=%b valid=%b last=%b expected 1/0/0/0",
               pkt_count, busy, ifc.bus_valid, ifc.bus_last);
    end
  endtask

  task automatic test_stall();
    int pops_before;
    beats.delete();
    ifc.bus_ready = 1'b1;
    fq = '{32'h0A010003, 32'h11, 32'h22, 32'h33};
    wait_beats(1, 20);
    ifc.bus_ready = 1'b0;
    pops_before = pops;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({ifc.bus_valid, ifc.bus_dest, ifc.bus_addr, ifc.bus_data, ifc.bus_last, last_rd} !==
          {1'b1, 8'h0A, 16'h0101, 32'h22, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold%0d valid=%b dest=%h addr=%h data=%h last=%b rd=%b expected 1/0a/0101/22/0/0",
                 i, ifc.bus_valid, ifc.bus_dest, ifc.bus_addr, ifc.bus_data, ifc.bus_last, last_rd);
      end
    end
    checks++;
    if (pops !== pops_before || pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL stall_no_pop pops=%0d pkt_count=%0d expected %0d/1", pops, pkt_count, pops_before);
    end
    ifc.bus_ready = 1'b1;
    wait_beats(3, 20);
    checks++;
    if (pk(beats[1]) !== {8'h0A, 16'h0101, 32'h22, 1'b0} ||
        pk(beats[2]) !== {8'h0A, 16'h0102, 32'h33, 1'b1}) begin
      failures++;
      $display("FAIL stall_beats b1=%h b2=%h", pk(beats[1]), pk(beats[2]));
    end
    checks++;
    if (beats.size() !== 3 || pkt_count !== 16'd2) begin
      failures++;
      $display("FAIL stall_done beats=%0d pkt_count=%0d expected 3/2", beats.size(), pkt_count);
    end
  endtask

  task automatic test_bad_header();
    beats.delete();
    hdr_pulses = 0;
    ifc.bus_ready = 1'b1;
    fq = '{32'h05000000, 32'h07020001, 32'hAA};
    step();
    checks++;
    if ({hdr_err, ifc.bus_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL bad_hdr_pulse hdr_err=%b valid=%b busy=%b expected 1/0/0", hdr_err, ifc.bus_valid, busy);
    end
    wait_beats(1, 20);
    checks++;
    if (pk(beats[0]) !== {8'h07, 16'h0200, 32'hAA, 1'b1}) begin
      failures++;
      $display("FAIL bad_hdr_next got=%h expected=%h", pk(beats[0]), {8'h07, 16'h0200, 32'hAA, 1'b1});
    end
    checks++;
    if (hdr_pulses !== 1 || pkt_count !== 16'd3) begin
      failures++;
      $display("FAIL bad_hdr_count pulses=%0d pkt_count=%0d expected 1/3", hdr_pulses, pkt_count);
    end
  endtask

  task automatic test_wrap();
    beats.delete();
    fq = '{32'h33FFFF02, 32'h1, 32'h2};
    wait_beats(2, 20);
    checks++;
    if (pk(beats[0]) !== {8'h33, 16'hFFFF, 32'h1, 1'b0}) begin
      failures++;
      $display("FAIL wrap_beat0 got=%h", pk(beats[0]));
    end
    checks++;
    if (pk(beats[1]) !== {8'h33, 16'h0000, 32'h2, 1'b1} || pkt_count !== 16'd4) begin
      failures++;
      $display("FAIL wrap_beat1 got=%h pkt_count=%0d expected addr 0000 count 4", pk(beats[1]), pkt_count);
    end
  endtask

  task automatic test_underrun();
    logic [56:0] exp_b [3];
    exp_b[0] = {8'h0C, 16'h0040, 32'hA1, 1'b0};
    exp_b[1] = {8'h0C, 16'h0041, 32'hA2, 1'b0};
    exp_b[2] = {8'h0C, 16'h0042, 32'hA3, 1'b1};
    beats.delete();
    pops = 0;
    fq = '{32'h0C004003, 32'hA1, 32'hA2, 32'hA3};
    wait_pops(2, 20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (last_rd !== 1'b0 || ifc.bus_valid !== 1'b0) begin
        failures++;
        $display("FAIL underrun_bubble%0d rd=%b valid=%b expected 0/0", i, last_rd, ifc.bus_valid);
      end
    end
    stall = 1'b0;
    wait_beats(3, 20);
    for (int i = 0; i < beats.size() && i < 3; i++) begin
      checks++;
      if (pk(beats[i]) !== exp_b[i]) begin
        failures++;
        $display("FAIL underrun_beat%0d got=%h expected=%h", i, pk(beats[i]), exp_b[i]);
      end
    end
    checks++;
    if (pops !== 4 || beats.size() !== 3 || pkt_count !== 16'd5) begin
      failures++;
      $display("FAIL underrun_done pops=%0d beats=%0d pkt_count=%0d expected 4/3/5",
               pops, beats.size(), pkt_count);
    end
  endtask

  task automatic test_back_to_back();
    beats.delete();
    fq = '{32'h01001001, 32'hB1, 32'h02002001, 32'hB2};
    wait_beats(2, 20);
    checks++;
    if (pk(beats[0]) !== {8'h01, 16'h0010, 32'hB1, 1'b1} ||
        pk(beats[1]) !== {8'h02, 16'h0020, 32'hB2, 1'b1}) begin
      failures++;
      $display("FAIL b2b_beats b0=%h b1=%h", pk(beats[0]), pk(beats[1]));
    end
    checks++;
    if (beats[1].cyc - beats[0].cyc !== 3 || pkt_count !== 16'd7) begin
      failures++;
      $display("FAIL b2b_spacing gap=%0d pkt_count=%0d expected 3/7",
               beats[1].cyc - beats[0].cyc, pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    beats.delete();
    pops = 0;
    ifc.bus_ready = 1'b0;
    fq = '{32'h09030004, 32'hC1, 32'h0B050001, 32'hD1};
    wait_pops(2, 20);
    checks++;
    if ({ifc.bus_valid, ifc.bus_data, busy} !== {1'b1, 32'hC1, 1'b1}) begin
      failures++;
      $display("FAIL mid_loaded valid=%b data=%h busy=%b expected 1/c1/1", ifc.bus_valid, ifc.bus_data, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ifc.bus_valid, ifc.bus_last, ifc.bus_dest, ifc.bus_addr, ifc.bus_data,
         hdr_err, busy, pkt_count, ifc.read_fifo_en} !== 77'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%b last=%b dest=%h addr=%h data=%h hdr_err=%b busy=%b cnt=%h rd=%b expected 0",
               ifc.bus_valid, ifc.bus_last, ifc.bus_dest, ifc.bus_addr, ifc.bus_data,
               hdr_err, busy, pkt_count, ifc.read_fifo_en);
    end
    step();
    step();
    checks++;
    if (pops !== 2) begin
      failures++;
      $display("FAIL mid_reset_pop pops=%0d expected 2", pops);
    end
    reset = 1'b1;
    ifc.bus_ready = 1'b1;
    wait_beats(1, 20);
    checks++;
    if (pk(beats[0]) !== {8'h0B, 16'h0500, 32'hD1, 1'b1} || pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL mid_next_hdr got=%h pkt_count=%0d expected %h/1",
               pk(beats[0]), pkt_count, {8'h0B, 16'h0500, 32'hD1, 1'b1});
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    pops       = 0;
    hdr_pulses = 0;
    last_rd    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_bad_header();
    test_wrap();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_dispatcher.md
BUS_DISPATCHER -- requirements
Module: bus_dispatcher

Interface
REQ-001 SHALL have parameter LEN_W, default 4, payload-length field width in bits (max packet 2^LEN_W-1 payload words).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port out_fifo  input  32  FIFO head word, show-ahead (valid whenever empty=0).
REQ-005 SHALL have port empty  input  1  FIFO empty flag.
REQ-006 SHALL have port read_fifo_en  output  1  pop request to FIFO, combinational.
REQ-007 SHALL have port bus_valid  output  1  bus beat valid.
REQ-008 SHALL have port bus_ready  input  1  bus beat accepted when high with bus_valid.
REQ-009 SHALL have port bus_dest  output  8  destination node id of current packet.
REQ-010 SHALL have port bus_addr  output  16  word address of current beat.
REQ-011 SHALL have port bus_data  output  32  payload word of current beat.
REQ-012 SHALL have port bus_last  output  1  high on final beat of packet.
REQ-013 SHALL have port hdr_err  output  1  one-cycle pulse on discarded illegal header.
REQ-014 SHALL have port pkt_count  output  16  count of fully delivered packets.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL decode header word: [31:24] dest, [23:8] base address, [LEN_W-1:0] length N; remaining bits ignored.
REQ-017 SHALL implement states IDLE, PAYLOAD, DRAIN.
REQ-018 SHALL assert read_fifo_en only when empty=0 and the current state consumes a word this cycle; never when empty=1.
REQ-019 IDLE, empty=0: pop header; N=0 -> pulse hdr_err next cycle, stay IDLE; N>0 -> latch dest/base, remaining=N, index=0, go PAYLOAD.
REQ-020 PAYLOAD: word loads when empty=0 and output slot free (bus_valid=0 or bus_ready=1); load pops FIFO and registers bus_data=out_fifo, bus_addr=base+index, bus_valid=1, bus_last=(remaining==1).
REQ-021 PAYLOAD: on load, remaining decrements, index increments; load of last word moves to DRAIN.
REQ-022 bus_addr SHALL wrap modulo 2^16 (base+index truncated to 16 bits).
REQ-023 SHALL sustain one beat per cycle within a packet while empty=0 and bus_ready=1.
REQ-024 bus_valid=1 with bus_ready=0 SHALL hold bus_valid, bus_dest, bus_addr, bus_data, bus_last stable; no pop that cycle.
REQ-025 Accept with no new load SHALL clear bus_valid next cycle; FIFO underrun mid-packet inserts bubbles, never drops or reorders words.
REQ-026 DRAIN: on bus_ready=1 clear bus_valid, bus_last, increment pkt_count (wraps 0xFFFF->0), go IDLE; no pop in DRAIN.
REQ-027 Header pop SHALL NOT occur before return to IDLE (minimum one idle cycle between packets).
REQ-028 busy SHALL be 0 in IDLE, 1 in PAYLOAD and DRAIN.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE and bus_valid=0, bus_last=0, bus_dest=0, bus_addr=0, bus_data=0, hdr_err=0, pkt_count=0, busy=0; read_fifo_en=0 while reset=0.
REQ-030 Reset mid-packet SHALL abandon the packet; remaining FIFO words are next treated as headers.
REQ-031 After reset release, first pop SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-032 Header 0x0A_0100_03 then 0x11,0x22,0x33, bus_ready=1 -> three consecutive beats dest=0x0A, addr 0x0100/0x0101/0x0102, data 0x11/0x22/0x33, bus_last on third, pkt_count=1.
REQ-033 Same packet, bus_ready=0 for 5 cycles on beat 2 -> beat 2 stable all 5 cycles, no pop, completion unchanged.
REQ-034 Header with N=0 followed by valid packet -> hdr_err pulses once, bus_valid stays 0 for it, next packet delivered normally.
REQ-035 Base 0xFFFF, N=2 -> addresses 0xFFFF then 0x0000.
REQ-036 empty=1 for 3 cycles between payload words 1 and 2 -> read_fifo_en=0 those cycles, words delivered in order, no duplication.
REQ-037 reset=0 asynchronously during PAYLOAD -> all outputs at reset values immediately, next FIFO word decoded as header.
